// File: rtl/rns_pkg.sv
// Shared types and widths for the RNS datapath blocks around Data_Mem.
package rns_pkg;

  localparam int NUM_DOMAINS = 1;
  localparam int DATA_WID    = NUM_DOMAINS * 8;

  // Which requester a pending one-cycle read belongs to
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PL   = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  // Arbiter state: normal pipeline priority, or a forced debug slot
  typedef enum logic {
    S_PL  = 1'b0,
    S_DBG = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter for the debug requester.
// at_limit looks at the value the counter will hold after this edge, so the
// arbiter can switch state in the same cycle the limit is reached.
module arb_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Next count: clear wins, increment saturates at the limit
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && (cnt != LIM)) begin
      cnt_nxt = cnt + CW'(1);
    end
    at_limit = (cnt_nxt == LIM);
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single Data_Mem port between the EX-stage load/store path and
// the debug/loader port. Pipeline has priority; a starvation counter forces a
// debug slot. Read data (one-cycle latency) is steered back to its requester.
module dmem_port_arbiter #(
  parameter int NUM_DOMAINS  = 1,
  parameter int ADDR_WID     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pl_req,
  input  logic                       pl_we,
  input  logic [ADDR_WID-1:0]        pl_addr,
  input  logic [NUM_DOMAINS*8-1:0]   pl_wdata,
  output logic                       pl_gnt,
  output logic                       pl_stall,
  output logic                       pl_rvalid,
  output logic [NUM_DOMAINS*8-1:0]   pl_rdata,
  input  logic                       dbg_req,
  input  logic                       dbg_we,
  input  logic [ADDR_WID-1:0]        dbg_addr,
  input  logic [NUM_DOMAINS*8-1:0]   dbg_wdata,
  output logic                       dbg_gnt,
  output logic                       dbg_rvalid,
  output logic [NUM_DOMAINS*8-1:0]   dbg_rdata,
  output logic [ADDR_WID-1:0]        mem_rd_addr,
  output logic [ADDR_WID-1:0]        mem_wr_addr,
  output logic [NUM_DOMAINS*8-1:0]   mem_wr_data,
  output logic                       mem_wr_en,
  input  logic [NUM_DOMAINS*8-1:0]   mem_dout
);

  import rns_pkg::*;

  localparam int DW = NUM_DOMAINS * 8;

  arb_state_t          state;
  owner_t              rd_owner;

  logic                dbg_sel;
  logic                any_gnt;
  logic                sel_we;
  logic [ADDR_WID-1:0] sel_addr;
  logic [DW-1:0]       sel_wdata;

  logic [ADDR_WID-1:0] rd_addr_q;
  logic [ADDR_WID-1:0] wr_addr_q;
  logic [DW-1:0]       wr_data_q;
  logic [DW-1:0]       pl_rdata_q;
  logic [DW-1:0]       dbg_rdata_q;

  logic                cnt_inc;
  logic                cnt_clr;
  logic                at_limit;

  // Grant decision; debug wins only in its forced slot or when the pipeline is idle
  always_comb begin
    dbg_sel  = dbg_req & ((state == S_DBG) | ~pl_req);
    dbg_gnt  = reset & dbg_sel;
    pl_gnt   = reset & pl_req & ~dbg_sel;
    pl_stall = reset & pl_req & ~pl_gnt;
    any_gnt  = pl_gnt | dbg_gnt;
  end

  // Steer the granted requester onto the memory port; idle port holds last addresses
  always_comb begin
    sel_we    = dbg_gnt ? dbg_we    : pl_we;
    sel_addr  = dbg_gnt ? dbg_addr  : pl_addr;
    sel_wdata = dbg_gnt ? dbg_wdata : pl_wdata;
    mem_wr_en = any_gnt & sel_we;
    mem_rd_addr = (any_gnt & ~sel_we) ? sel_addr  : rd_addr_q;
    mem_wr_addr = (any_gnt &  sel_we) ? sel_addr  : wr_addr_q;
    mem_wr_data = (any_gnt &  sel_we) ? sel_wdata : wr_data_q;
  end

  // Read return: valid to the recorded owner only, the other side keeps its last data
  always_comb begin
    pl_rvalid  = (rd_owner == OWN_PL);
    dbg_rvalid = (rd_owner == OWN_DBG);
    pl_rdata   = pl_rvalid  ? mem_dout : pl_rdata_q;
    dbg_rdata  = dbg_rvalid ? mem_dout : dbg_rdata_q;
  end

  // Debug is being starved only while the pipeline holds priority over it
  always_comb begin
    cnt_inc = (state == S_PL) & pl_req & dbg_req;
    cnt_clr = dbg_gnt | ~dbg_req;
  end

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (cnt_inc),
    .clr      (cnt_clr),
    .at_limit (at_limit)
  );

  // Arbitration FSM and read-owner tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_PL;
      rd_owner <= OWN_NONE;
    end else begin
      case (state)
        S_PL:    if (at_limit) state <= S_DBG;
        S_DBG:   state <= S_PL;
        default: state <= S_PL;
      endcase
      if (any_gnt && !sel_we) begin
        rd_owner <= dbg_gnt ? OWN_DBG : OWN_PL;
      end else begin
        rd_owner <= OWN_NONE;
      end
    end
  end

  // Holding registers for idle-port addresses and the last returned read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      pl_rdata_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      rd_addr_q   <= mem_rd_addr;
      wr_addr_q   <= mem_wr_addr;
      wr_data_q   <= mem_wr_data;
      pl_rdata_q  <= pl_rdata;
      dbg_rdata_q <= dbg_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter with a request-level reference model.
module tb_dmem_port_arbiter;

  localparam int ND = 1;
  localparam int AW = 16;
  localparam int SL = 4;
  localparam int DW = ND * 8;

  logic          clk;
  logic          reset;
  logic          pl_req, pl_we, dbg_req, dbg_we;
  logic [AW-1:0] pl_addr, dbg_addr;
  logic [DW-1:0] pl_wdata, dbg_wdata;
  logic          pl_gnt, pl_stall, pl_rvalid, dbg_gnt, dbg_rvalid, mem_wr_en;
  logic [DW-1:0] pl_rdata, dbg_rdata, mem_wr_data, mem_dout;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;

  dmem_port_arbiter #(
    .NUM_DOMAINS  (ND),
    .ADDR_WID     (AW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pl_req      (pl_req),
    .pl_we       (pl_we),
    .pl_addr     (pl_addr),
    .pl_wdata    (pl_wdata),
    .pl_gnt      (pl_gnt),
    .pl_stall    (pl_stall),
    .pl_rvalid   (pl_rvalid),
    .pl_rdata    (pl_rdata),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_gnt     (dbg_gnt),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_dout    (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial memory image, shared by the Data_Mem stand-in and the model
  function automatic logic [7:0] init_val(input logic [15:0] a);
    case (a)
      16'h0010: init_val = 8'hA5;
      16'h0001: init_val = 8'h11;
      16'h0002: init_val = 8'h22;
      default:  init_val = 8'(a * 7 + 3);
    endcase
  endfunction

  // Data_Mem stand-in: registered read, write on enable
  logic [7:0] mem     [0:65535];
  bit         written [0:65535];
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_wr_addr]     <= mem_wr_data;
      written[mem_wr_addr] <= 1'b1;
    end
    mem_dout <= written[mem_rd_addr] ? mem[mem_rd_addr] : init_val(mem_rd_addr);
  end

  // Reference model state
  logic [7:0] ref_mem [0:65535];
  int         streak;
  int         pend_own;
  logic [7:0] pend_data, last_pl, last_dbg;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at edge+1, check at edge+3, update model at the edge
  task automatic step(input logic pr, input logic pw, input logic [15:0] pa, input logic [7:0] pd,
                      input logic dr, input logic dw, input logic [15:0] da, input logic [7:0] dd,
                      output logic got_dg);
    logic        e_pg, e_dg, g_we;
    logic [15:0] g_a;
    logic [7:0]  g_d;
    pl_req = pr; pl_we = pw; pl_addr = pa; pl_wdata = pd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #2;
    e_dg = dr && (!pr || streak == SL);
    e_pg = pr && !e_dg;
    g_we = e_dg ? dw : pw;
    g_a  = e_dg ? da : pa;
    g_d  = e_dg ? dd : pd;
    got_dg = dbg_gnt;
    chk("pl_gnt", pl_gnt, e_pg);
    chk("dbg_gnt", dbg_gnt, e_dg);
    chk("pl_stall", pl_stall, pr && !e_pg);
    chk("mem_wr_en", mem_wr_en, (e_pg || e_dg) && g_we);
    if (e_pg || e_dg) begin
      if (g_we) begin
        chk("mem_wr_addr", mem_wr_addr, g_a);
        chk("mem_wr_data", mem_wr_data, g_d);
      end else begin
        chk("mem_rd_addr", mem_rd_addr, g_a);
      end
    end
    chk("pl_rvalid", pl_rvalid, pend_own == 1);
    chk("dbg_rvalid", dbg_rvalid, pend_own == 2);
    chk("pl_rdata", pl_rdata, (pend_own == 1) ? pend_data : last_pl);
    chk("dbg_rdata", dbg_rdata, (pend_own == 2) ? pend_data : last_dbg);
    @(posedge clk);
    if (pend_own == 1) last_pl = pend_data;
    if (pend_own == 2) last_dbg = pend_data;
    pend_own = 0;
    if (e_pg || e_dg) begin
      if (g_we) ref_mem[g_a] = g_d;
      else begin
        pend_own  = e_dg ? 2 : 1;
        pend_data = ref_mem[g_a];
      end
    end
    streak = (!dr || e_dg) ? 0 : ((streak < SL) ? streak + 1 : SL);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_pl_gnt"}, pl_gnt, 0);
    chk({tag, "_dbg_gnt"}, dbg_gnt, 0);
    chk({tag, "_pl_stall"}, pl_stall, 0);
    chk({tag, "_pl_rvalid"}, pl_rvalid, 0);
    chk({tag, "_dbg_rvalid"}, dbg_rvalid, 0);
    chk({tag, "_wr_en"}, mem_wr_en, 0);
  endtask

  // Reset with whatever requests are currently driven still active
  task automatic do_reset(input int n);
    streak = 0; pend_own = 0; last_pl = '0; last_dbg = '0;
    if (reset) begin
      reset = 1'b0;
      #1;
      check_quiet("rst_async");
    end
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check_quiet("rst_hold");
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_pl_rdata", pl_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    reset = 1'b1;
  endtask

  logic       dg;
  logic [9:0] pattern;
  logic       r_pr, r_pw, r_dr, r_dw;
  logic [15:0] r_pa, r_da;

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    reset = 1'b0;
    pl_req = 1'b1; pl_we = 1'b0; pl_addr = 16'h0010; pl_wdata = '0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0040; dbg_wdata = 8'h77;

    // Reset held with both requests active
    do_reset(3);

    // Pipeline load from 0x0010
    step(1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00, dg);
    chk("pl_load_rvalid", pl_rvalid, 1);
    chk("pl_load_data", pl_rdata, 8'hA5);
    chk("pl_load_dbg_rvalid", dbg_rvalid, 0);
    step(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, dg);

    // Debug write then pipeline read-back
    step(0, 0, 16'h0000, 8'h00, 1, 1, 16'h0200, 8'h3C, dg);
    chk("dbg_wr_gnt", dg, 1);
    step(1, 0, 16'h0200, 8'h00, 0, 0, 16'h0000, 8'h00, dg);
    chk("raw_data", pl_rdata, 8'h3C);

    // Alternating owners on back-to-back reads
    step(1, 0, 16'h0001, 8'h00, 0, 0, 16'h0000, 8'h00, dg);
    chk("alt_pl_data", pl_rdata, 8'h11);
    chk("alt_pl_only", dbg_rvalid, 0);
    step(0, 0, 16'h0000, 8'h00, 1, 0, 16'h0002, 8'h00, dg);
    chk("alt_dbg_data", dbg_rdata, 8'h22);
    chk("alt_dbg_only", pl_rvalid, 0);
    step(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, dg);

    // Contention: debug slot every SL+1 cycles
    pattern = '0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 16'(i), 8'h00, 1, 0, 16'(100 + i), 8'h00, dg);
      pattern[i] = dg;
    end
    chk("contention_pattern", pattern, 10'b10_0001_0000);
    step(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, dg);

    // Reset the cycle after a debug read grant
    step(0, 0, 16'h0000, 8'h00, 1, 0, 16'h0002, 8'h00, dg);
    do_reset(2);
    step(1, 0, 16'h0003, 8'h00, 1, 0, 16'h0004, 8'h00, dg);
    chk("post_rst_dbg_rvalid", dbg_rvalid, 0);
    pattern = '0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 16'h0005, 8'h00, 1, 0, 16'h0006, 8'h00, dg);
      pattern[i] = dg;
    end
    chk("post_rst_starve", pattern, 10'b00_0000_1000);

    // Randomized traffic, debug mostly holding its request until granted
    r_dr = 0; r_dw = 0; r_da = '0;
    for (int n = 0; n < 3000; n++) begin
      r_pr = ($urandom_range(0, 99) < 70);
      r_pw = $urandom_range(0, 1) == 1;
      r_pa = 16'($urandom_range(0, 31));
      if (!r_dr || dg || $urandom_range(0, 19) == 0) begin
        r_dr = ($urandom_range(0, 99) < 50);
        r_dw = $urandom_range(0, 1) == 1;
        r_da = 16'($urandom_range(0, 31));
      end
      step(r_pr, r_pw, r_pa, 8'($urandom), r_dr, r_dw, r_da, 8'($urandom), dg);
      if ($urandom_range(0, 599) == 0) do_reset(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
